// File: rtl/rom_dump_sequencer.sv
// rom_dump_sequencer
// Walks every address of an attached bipolar PROM, drives the V1..V4 read
// operation, waits a fixed access time, captures the data word and offers
// each address/data pair downstream over a valid/ready handshake.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | chip deselected, waiting for start
// ACCESS     | address and read operation settling, access timer running
// PRESENT    | captured word offered downstream, held until accepted
// STEP_WAIT  | next address driven, waiting for a step pulse (step mode)
// DONE       | one-cycle completion pulse after the last word was accepted
module rom_dump_sequencer #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 9,
    parameter int ACCESS_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     step_mode,
    input  logic                     step,
    input  logic [DATA_WIDTH-1:0]    rom_data_in,
    output logic [3:0]               rom_operation,
    output logic [ADDRESS_WIDTH-1:0] rom_address,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [ADDRESS_WIDTH-1:0] out_addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ACCESS    = 3'd1;
    localparam logic [2:0] ST_PRESENT   = 3'd2;
    localparam logic [2:0] ST_STEP_WAIT = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    localparam logic [3:0] OP_READ   = 4'b1100;
    localparam logic [3:0] OP_DESEL  = 4'b1111;

    localparam int              CNT_W      = $clog2(ACCESS_CYCLES + 1);
    // Timer counts down to zero; capture happens on the edge where it reads zero.
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(ACCESS_CYCLES - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] wait_cnt;

    // Sequencer state, access timer, chip pins and output word register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            wait_cnt      <= CNT_RELOAD;
            rom_operation <= OP_DESEL;
            rom_address   <= '0;
            out_data      <= '0;
            out_addr      <= '0;
            out_valid     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        rom_address   <= '0;
                        rom_operation <= OP_READ;
                        wait_cnt      <= CNT_RELOAD;
                        state         <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (abort) begin
                        state         <= ST_IDLE;
                        out_valid     <= 1'b0;
                        rom_operation <= OP_DESEL;
                    end else if (wait_cnt == '0) begin
                        out_data  <= rom_data_in;
                        out_addr  <= rom_address;
                        out_valid <= 1'b1;
                        state     <= ST_PRESENT;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                ST_PRESENT: begin
                    if (abort) begin
                        state         <= ST_IDLE;
                        out_valid     <= 1'b0;
                        rom_operation <= OP_DESEL;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (rom_address == '1) begin
                            rom_operation <= OP_DESEL;
                            state         <= ST_DONE;
                        end else begin
                            // Address only moves here, so captured data always
                            // comes from a settled address.
                            rom_address <= rom_address + ADDRESS_WIDTH'(1);
                            if (step_mode) begin
                                state <= ST_STEP_WAIT;
                            end else begin
                                wait_cnt <= CNT_RELOAD;
                                state    <= ST_ACCESS;
                            end
                        end
                    end
                end
                ST_STEP_WAIT: begin
                    if (abort) begin
                        state         <= ST_IDLE;
                        out_valid     <= 1'b0;
                        rom_operation <= OP_DESEL;
                    end else if (step) begin
                        wait_cnt <= CNT_RELOAD;
                        state    <= ST_ACCESS;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state         <= ST_IDLE;
                    out_valid     <= 1'b0;
                    rom_operation <= OP_DESEL;
                end
            endcase
        end
    end

    // Status flags decoded straight from the state register.
    always_comb begin
        busy = (state == ST_ACCESS) || (state == ST_PRESENT) || (state == ST_STEP_WAIT);
        done = (state == ST_DONE);
    end

endmodule
